// File: rtl/divider_pkg.sv
// Shared types for the cpu32e2 iterative divider: boolean, divide mode,
// sequencer state and the start/mode control bus, plus control-word shorthands.
`ifndef DIVIDER_PKG_SV
`define DIVIDER_PKG_SV

package boolPkg;
    typedef enum logic {
        FALSE = 1'b0,
        TRUE  = 1'b1
    } bool_t;
endpackage

package dividerGroup;
    import boolPkg::*;

    typedef enum logic {
        DIV_UNSIGNED = 1'b0,
        DIV_SIGNED   = 1'b1
    } divideMode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITERATE = 2'd1,
        FIXUP   = 2'd2,
        DONE    = 2'd3
    } dividerState_t;

    typedef struct packed {
        bool_t       start;
        divideMode_t divideMode;
    } controlBus;
endpackage

`define NO_OP dividerGroup::controlBus'{start: boolPkg::FALSE, divideMode: dividerGroup::DIV_UNSIGNED}
`define DIV_U dividerGroup::controlBus'{start: boolPkg::TRUE, divideMode: dividerGroup::DIV_UNSIGNED}
`define DIV_S dividerGroup::controlBus'{start: boolPkg::TRUE, divideMode: dividerGroup::DIV_SIGNED}

`endif

// File: rtl/divider_if.sv
// Operand/result bundle between the execute-stage sequencer and the divider.
interface divider_if
    import dividerGroup::*;
#(
    parameter int unsigned WIDTH = 32
) ();
    controlBus        dividerControl;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dividerQuotient;
    logic [WIDTH-1:0] dividerRemainder;
    logic             divideByZero;

    modport master (
        output dividerControl, dividend, divisor,
        input  busy, done, dividerQuotient, dividerRemainder, divideByZero
    );

    modport slave (
        input  dividerControl, dividend, divisor,
        output busy, done, dividerQuotient, dividerRemainder, divideByZero
    );
endinterface

// File: rtl/divider.sv
// Radix-2 restoring divider: magnitudes are divided over WIDTH iterations,
// then signs are reapplied (truncating division) in a single fixup cycle.
module divider
    import dividerGroup::*;
    import boolPkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     resetN,
    divider_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    dividerState_t    state;
    dividerState_t    next_state;
    logic             accept;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor_mag;
    logic [CNT_W-1:0] count;
    logic             quot_neg;
    logic             rem_neg;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             dbz;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH:0]   trial;
    logic             borrow;

    always_comb begin
        sign_a = (bus.dividerControl.divideMode == DIV_SIGNED) & bus.dividend[WIDTH-1];
        sign_b = (bus.dividerControl.divideMode == DIV_SIGNED) & bus.divisor[WIDTH-1];
    end

    // Partial remainder never reaches bit WIDTH-1 before the final shift,
    // so dropping rem's top bit from the trial is safe.
    always_comb begin
        trial  = {1'b0, rem[WIDTH-2:0], dq[WIDTH-1]} - {1'b0, divisor_mag};
        borrow = trial[WIDTH];
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        bus.busy   = (state != IDLE);
        bus.done   = (state == DONE);
        case (state)
            IDLE: begin
                if (bus.dividerControl.start == TRUE) begin
                    accept     = 1'b1;
                    next_state = (bus.divisor == '0) ? DONE : ITERATE;
                end
            end
            ITERATE: if (count == '0) next_state = FIXUP;
            FIXUP:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dq          <= '0;
            rem         <= '0;
            divisor_mag <= '0;
            count       <= '0;
            quot_neg    <= 1'b0;
            rem_neg     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            dbz         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dq          <= sign_a ? negate(bus.dividend) : bus.dividend;
                        divisor_mag <= sign_b ? negate(bus.divisor) : bus.divisor;
                        quot_neg    <= sign_a ^ sign_b;
                        rem_neg     <= sign_a;
                        rem         <= '0;
                        count       <= CNT_W'(WIDTH - 1);
                        dbz         <= 1'b0;
                        if (bus.divisor == '0) begin
                            quotient  <= '1;
                            remainder <= bus.dividend;
                            dbz       <= 1'b1;
                        end
                    end
                end
                ITERATE: begin
                    rem   <= borrow ? {rem[WIDTH-2:0], dq[WIDTH-1]} : trial[WIDTH-1:0];
                    dq    <= {dq[WIDTH-2:0], ~borrow};
                    count <= count - CNT_W'(1);
                end
                FIXUP: begin
                    quotient  <= quot_neg ? negate(dq) : dq;
                    remainder <= rem_neg ? negate(rem) : rem;
                end
                default: ;
            endcase
        end
    end

    assign bus.dividerQuotient  = quotient;
    assign bus.dividerRemainder = remainder;
    assign bus.divideByZero     = dbz;
endmodule
